// File: rtl/mov_pipe.sv
// mov_pipe: pipelined register-move unit (MOV / MVN / CMOV / MOVZ).
// The move result is computed when an operation enters stage 0 and then
// rides through DEPTH elastic stages with valid/ready handshaking.
// Optional feature: define MOV_PIPE_CNT_EN to add a saturating 16-bit
// output-transfer counter on port xfer_cnt.
module mov_pipe #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [N-1:0] in_dest,
    input  logic [1:0]   mode,
    input  logic         cond,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
`ifdef MOV_PIPE_CNT_EN
    ,
    output logic [15:0]  xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_MOV  = 2'b00,
        MODE_MVN  = 2'b01,
        MODE_CMOV = 2'b10,
        MODE_MOVZ = 2'b11
    } mode_t;

    logic [DEPTH-1:0] stage_valid;
    logic [N-1:0]     stage_data [DEPTH];
    logic [DEPTH-1:0] stage_load;
    logic [N-1:0]     result;
    logic             in_xfer;

    // A stage may load when it is empty or its contents leave this cycle;
    // that holds exactly when out_ready is high or some stage at or beyond it is empty.
    always_comb begin : ready_chain
        logic chain;
        chain      = out_ready;
        stage_load = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain         = chain || !stage_valid[k];
            stage_load[k] = chain;
        end
    end

    // Reset blocks acceptance outright so nothing slips in while flushing.
    assign in_ready = !rst && stage_load[0];
    assign in_xfer  = in_valid && in_ready;

    // Move result from the operands presented at the input.
    always_comb begin
        result = '0;
        case (mode_t'(mode))
            MODE_MOV:  result = in_data;
            MODE_MVN:  result = ~in_data;
            MODE_CMOV: result = cond ? in_data : in_dest;
            MODE_MOVZ: result = '0;
            default:   result = '0;
        endcase
    end

    // Stage 0 captures a new operation only on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid[0] <= 1'b0;
            stage_data[0]  <= '0;
        end else if (stage_load[0]) begin
            stage_valid[0] <= in_xfer;
            if (in_xfer) begin
                stage_data[0] <= result;
            end
        end
    end

    // Later stages pull from the previous stage; data is only overwritten by a
    // valid operation so an idle output keeps showing its last result.
    for (genvar k = 1; k < DEPTH; k++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_valid[k] <= 1'b0;
                stage_data[k]  <= '0;
            end else if (stage_load[k]) begin
                stage_valid[k] <= stage_valid[k-1];
                if (stage_valid[k-1]) begin
                    stage_data[k] <= stage_data[k-1];
                end
            end
        end
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];
    assign busy      = |stage_valid;

`ifdef MOV_PIPE_CNT_EN
    // Count output transfers, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= 16'h0000;
        end else if (out_valid && out_ready && (xfer_cnt != 16'hFFFF)) begin
            xfer_cnt <= xfer_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_mov_pipe.sv
// tb_mov_pipe: directed self-checking bench for mov_pipe (N=32, DEPTH=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mov_pipe;

    localparam int N     = 32;
    localparam int DEPTH = 2;

    localparam logic [1:0] M_MOV  = 2'b00;
    localparam logic [1:0] M_MVN  = 2'b01;
    localparam logic [1:0] M_CMOV = 2'b10;
    localparam logic [1:0] M_MOVZ = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [N-1:0] in_dest;
    logic [1:0]   mode;
    logic         cond;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         busy;
`ifdef MOV_PIPE_CNT_EN
    logic [15:0]  xfer_cnt;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    mov_pipe #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .cond      (cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef MOV_PIPE_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] m, input logic [N-1:0] d,
                            input logic [N-1:0] dest, input logic c);
        in_valid = 1'b1;
        mode     = m;
        in_data  = d;
        in_dest  = dest;
        cond     = c;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        drive_op(M_MOV, 32'h1234_5678, 32'h0, 1'b0);
        #1;
        n_compared++;
        if (in_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        step();
        step();
        n_compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: got valid=%b busy=%b data=%h expected 0/0/00000000",
                     out_valid, busy, out_data);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_discard: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive_op(M_MOV, 32'hDEAD_BEEF, 32'h0, 1'b0);
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL latency_in_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_compared++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL latency_cycle1: got valid=%b busy=%b expected 0/1", out_valid, busy);
        end
        step();
        n_compared++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            n_mismatched++;
            $display("[TB] FAIL latency_cycle2: got valid=%b data=%h expected 1/deadbeef",
                     out_valid, out_data);
        end
        step();
        n_compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL latency_one_wide: got valid=%b busy=%b expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_input_ignore();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode    = 2'(i);
            in_data = $urandom;
            in_dest = $urandom;
            cond    = 1'(i);
            step();
        end
        n_compared++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_idle: got busy=%b valid=%b data=%h expected 0/0/deadbeef",
                     busy, out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   ops_mode [4] = '{M_MOV, M_MVN, M_MOVZ, M_CMOV};
        logic [N-1:0] ops_data [4] = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'h9999_9999};
        logic [N-1:0] expect_q [4] = '{32'h1, 32'hFFFF_FFFF, 32'h0, 32'h55};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive_op(ops_mode[i], ops_data[i], 32'h55, 1'b0);
            else       in_valid = 1'b0;
            step();
            if (i >= 1 && i <= 4) begin
                n_compared++;
                if (out_valid !== 1'b1 || out_data !== expect_q[i-1]) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_out%0d: got valid=%b data=%h expected 1/%h",
                             i - 1, out_valid, out_data, expect_q[i-1]);
                end
            end
        end
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_tail: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_op(M_MOV, 32'h11, 32'h0, 1'b0);
        step();
        drive_op(M_MOV, 32'h22, 32'h0, 1'b0);
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL bp_second_accept: got in_ready=%b expected 1", in_ready);
        end
        step();
        drive_op(M_MOV, 32'h33, 32'h0, 1'b0);
        n_compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11) begin
            n_mismatched++;
            $display("[TB] FAIL bp_full: got in_ready=%b valid=%b data=%h expected 0/1/00000011",
                     in_ready, out_valid, out_data);
        end
        step();
        step();
        n_compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL bp_hold: got in_ready=%b valid=%b data=%h busy=%b expected 0/1/00000011/1",
                     in_ready, out_valid, out_data, busy);
        end
        out_ready = 1'b1;
        #1;
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL bp_release_ready: got in_ready=%b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_compared++;
        if (out_valid !== 1'b1 || out_data !== 32'h22) begin
            n_mismatched++;
            $display("[TB] FAIL bp_drain1: got valid=%b data=%h expected 1/00000022", out_valid, out_data);
        end
        step();
        n_compared++;
        if (out_valid !== 1'b1 || out_data !== 32'h33) begin
            n_mismatched++;
            $display("[TB] FAIL bp_drain2: got valid=%b data=%h expected 1/00000033", out_valid, out_data);
        end
        step();
        n_compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_empty: got valid=%b busy=%b expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_full_throughput();
        logic [N-1:0] exp_val;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                if (i % 2 == 1) drive_op(M_CMOV, 32'h100 + 32'(i), 32'hAAAA, 1'b1);
                else            drive_op(M_MOV,  32'h100 + 32'(i), 32'h0,    1'b0);
                n_compared++;
                if (in_ready !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL full_in_ready%0d: got %b expected 1", i, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 6) begin
                exp_val = 32'h100 + 32'(i - 1);
                n_compared++;
                if (out_valid !== 1'b1 || out_data !== exp_val || busy !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL full_out%0d: got valid=%b data=%h busy=%b expected 1/%h/1",
                             i - 1, out_valid, out_data, busy, exp_val);
                end
            end
        end
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL full_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        drive_op(M_MOV, 32'h77, 32'h0, 1'b0);
        step();
        drive_op(M_MOV, 32'h88, 32'h0, 1'b0);
        step();
        in_valid = 1'b0;
        n_compared++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h77) begin
            n_mismatched++;
            $display("[TB] FAIL flush_loaded: got busy=%b valid=%b data=%h expected 1/1/00000077",
                     busy, out_valid, out_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_cleared: got valid=%b busy=%b data=%h expected 0/0/00000000",
                     out_valid, busy, out_data);
        end
        out_ready = 1'b1;
        drive_op(M_MVN, 32'h0F0F_0F0F, 32'h0, 1'b0);
        step();
        in_valid = 1'b0;
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_post_early: got valid=%b expected 0", out_valid);
        end
        step();
        n_compared++;
        if (out_valid !== 1'b1 || out_data !== 32'hF0F0_F0F0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_post_out: got valid=%b data=%h expected 1/f0f0f0f0",
                     out_valid, out_data);
        end
        step();
    endtask

`ifdef MOV_PIPE_CNT_EN
    task automatic test_counter();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        n_compared++;
        if (xfer_cnt !== 16'h0) begin
            n_mismatched++;
            $display("[TB] FAIL cnt_reset: got %h expected 0000", xfer_cnt);
        end
        drive_op(M_MOV, 32'h1, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        n_compared++;
        if (xfer_cnt !== 16'd8) begin
            n_mismatched++;
            $display("[TB] FAIL cnt_partial: got %0d expected 8", xfer_cnt);
        end
        for (int i = 0; i < 32'h10000; i++) step();
        n_compared++;
        if (xfer_cnt !== 16'hFFFF) begin
            n_mismatched++;
            $display("[TB] FAIL cnt_saturate: got %h expected ffff", xfer_cnt);
        end
        step();
        step();
        n_compared++;
        if (xfer_cnt !== 16'hFFFF) begin
            n_mismatched++;
            $display("[TB] FAIL cnt_hold: got %h expected ffff", xfer_cnt);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        n_compared++;
        if (xfer_cnt !== 16'h0) begin
            n_mismatched++;
            $display("[TB] FAIL cnt_clear: got %h expected 0000", xfer_cnt);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        mode      = M_MOV;
        cond      = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_latency();
        test_input_ignore();
        test_back_to_back();
        test_backpressure();
        test_full_throughput();
        test_reset_flush();
`ifdef MOV_PIPE_CNT_EN
        test_counter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
